// File: rtl/clarvi_pkg.sv
// clarvi_pkg: shared FSM state and command-register types for the Avalon pipe.
package clarvi_pkg;
    localparam int MAX_ADDR_WIDTH = 32;
    localparam int MAX_DATA_WIDTH = 64;
    localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

    typedef enum logic {IDLE, CMD} state_t;

    // Sized for the widest legal configuration; narrower builds zero-extend.
    typedef struct packed {
        logic                      write;
        logic [MAX_ADDR_WIDTH-1:0] address;
        logic [MAX_BE_WIDTH-1:0]   byteenable;
        logic [MAX_DATA_WIDTH-1:0] writedata;
    } cmd_t;
endpackage

// File: rtl/clarvi_latency_pipe.sv
// clarvi_latency_pipe: DEPTH-stage valid shift register standing in for readdatavalid on fixed-latency slaves.
module clarvi_latency_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic in_valid,
    output logic out_valid
);
    logic [DEPTH-1:0] sr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) sr <= '0;
        else       sr <= (sr << 1) | DEPTH'(in_valid);
    end

    assign out_valid = sr[DEPTH-1];
endmodule

// File: rtl/clarvi_avalon_pipe.sv
// clarvi_avalon_pipe: core request port to Avalon-MM master bridge with back-to-back
// command issue, outstanding-read tracking and optional fixed-latency response timing.
module clarvi_avalon_pipe
    import clarvi_pkg::*;
#(
    parameter int ADDR_WIDTH        = 14,
    parameter int DATA_WIDTH        = 32,
    parameter int MAX_PENDING       = 4,
    parameter int USE_READDATAVALID = 1,
    parameter int FIXED_LATENCY     = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               core_req_valid,
    output logic                               core_req_ready,
    input  logic                               core_req_write,
    input  logic [ADDR_WIDTH-1:0]              core_req_address,
    input  logic [DATA_WIDTH/8-1:0]            core_req_byteenable,
    input  logic [DATA_WIDTH-1:0]              core_req_writedata,
    output logic                               core_rsp_valid,
    output logic [DATA_WIDTH-1:0]              core_rsp_data,
    input  logic                               cpu_mem_pause,
    output logic [ADDR_WIDTH-1:0]              avm_address,
    output logic [DATA_WIDTH/8-1:0]            avm_byteenable,
    output logic                               avm_read,
    output logic                               avm_write,
    output logic [DATA_WIDTH-1:0]              avm_writedata,
    input  logic                               avm_waitrequest,
    input  logic [DATA_WIDTH-1:0]              avm_readdata,
    input  logic                               avm_readdatavalid,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_count,
    output logic                               protocol_error
);
    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] MAXP = CW'(MAX_PENDING);

    state_t state, state_n;
    cmd_t   cmd;
    logic   hs, rd_hs, rsp, unused_hi;

    assign core_req_ready = !cpu_mem_pause && (state == IDLE || !avm_waitrequest) &&
                            (core_req_write || pending_count < MAXP);
    assign hs    = core_req_valid && core_req_ready;
    assign rd_hs = hs && !core_req_write;

    always_comb begin
        state_n = state;
        state_n = hs ? CMD : (state == CMD && !avm_waitrequest) ? IDLE : state;
    end

    // A new command can only load when the previous one is accepted, so fields never move under waitrequest.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cmd   <= '0;
        end else begin
            state <= state_n;
            if (hs)
                cmd <= '{write:      core_req_write,
                         address:    MAX_ADDR_WIDTH'(core_req_address),
                         byteenable: MAX_BE_WIDTH'(core_req_byteenable),
                         writedata:  MAX_DATA_WIDTH'(core_req_writedata)};
        end
    end

    assign avm_read       = state == CMD && !cmd.write;
    assign avm_write      = state == CMD && cmd.write;
    assign avm_address    = cmd.address[ADDR_WIDTH-1:0];
    assign avm_byteenable = cmd.byteenable[DATA_WIDTH/8-1:0];
    assign avm_writedata  = cmd.writedata[DATA_WIDTH-1:0];
    assign unused_hi      = ^{cmd.address >> ADDR_WIDTH, cmd.byteenable >> (DATA_WIDTH/8),
                              cmd.writedata >> DATA_WIDTH};

    generate
        if (USE_READDATAVALID != 0) begin : g_var
            assign rsp = avm_readdatavalid;
        end else begin : g_fix
            logic accept;
            assign accept = avm_read && !avm_waitrequest;
            clarvi_latency_pipe #(.DEPTH(FIXED_LATENCY)) u_pipe (
                .clock     (clock),
                .reset     (reset),
                .in_valid  (accept),
                .out_valid (rsp)
            );
        end
    endgenerate

    assign core_rsp_valid = rsp;
    assign core_rsp_data  = avm_readdata;

    // A response with nothing outstanding is flagged and the count held at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_count  <= '0;
            protocol_error <= 1'b0;
        end else begin
            if (rsp && pending_count == '0) protocol_error <= 1'b1;
            if (rd_hs && !rsp)
                pending_count <= pending_count + 1'b1;
            else if (rsp && !rd_hs && pending_count != '0)
                pending_count <= pending_count - 1'b1;
        end
    end
endmodule

// File: tb/tb_clarvi_avalon_pipe.sv
// tb_clarvi_avalon_pipe: directed bench with a transaction-level reference model for a
// variable-latency instance (0) and a fixed-latency-2 instance (1).
module tb_clarvi_avalon_pipe;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MP = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          valid[2], write[2], pause[2], wreq[2], rdv[2];
    logic [AW-1:0] addr[2];
    logic [BW-1:0] be[2];
    logic [DW-1:0] wdata[2], rdata[2];

    logic          ready[2], rvalid[2], aread[2], awrite[2], perr[2];
    logic [DW-1:0] rsp_d[2], awd[2];
    logic [AW-1:0] aaddr[2];
    logic [BW-1:0] abe[2];
    logic [2:0]    pend[2];

    clarvi_avalon_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_PENDING(MP),
                         .USE_READDATAVALID(1), .FIXED_LATENCY(1)) u_var (
        .clock(clk), .reset(rst),
        .core_req_valid(valid[0]), .core_req_ready(ready[0]), .core_req_write(write[0]),
        .core_req_address(addr[0]), .core_req_byteenable(be[0]), .core_req_writedata(wdata[0]),
        .core_rsp_valid(rvalid[0]), .core_rsp_data(rsp_d[0]), .cpu_mem_pause(pause[0]),
        .avm_address(aaddr[0]), .avm_byteenable(abe[0]), .avm_read(aread[0]),
        .avm_write(awrite[0]), .avm_writedata(awd[0]), .avm_waitrequest(wreq[0]),
        .avm_readdata(rdata[0]), .avm_readdatavalid(rdv[0]),
        .pending_count(pend[0]), .protocol_error(perr[0])
    );

    clarvi_avalon_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_PENDING(MP),
                         .USE_READDATAVALID(0), .FIXED_LATENCY(2)) u_fix (
        .clock(clk), .reset(rst),
        .core_req_valid(valid[1]), .core_req_ready(ready[1]), .core_req_write(write[1]),
        .core_req_address(addr[1]), .core_req_byteenable(be[1]), .core_req_writedata(wdata[1]),
        .core_rsp_valid(rvalid[1]), .core_rsp_data(rsp_d[1]), .cpu_mem_pause(pause[1]),
        .avm_address(aaddr[1]), .avm_byteenable(abe[1]), .avm_read(aread[1]),
        .avm_write(awrite[1]), .avm_writedata(awd[1]), .avm_waitrequest(wreq[1]),
        .avm_readdata(rdata[1]), .avm_readdatavalid(rdv[1]),
        .pending_count(pend[1]), .protocol_error(perr[1])
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one issued command in flight on the bus plus an outstanding-read count.
    bit            m_busy[2], m_wr[2], m_err[2];
    logic [AW-1:0] m_a[2];
    logic [BW-1:0] m_be[2];
    logic [DW-1:0] m_d[2];
    int            m_pend[2];
    int            due[$];
    int            cyc = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit er, ev, hs, inc;
            if (rst) begin
                m_busy[i] = 0; m_wr[i] = 0; m_err[i] = 0; m_pend[i] = 0;
                m_a[i] = '0; m_be[i] = '0; m_d[i] = '0;
                if (i == 1) due.delete();
            end
            er = !pause[i] && (!m_busy[i] || !wreq[i]) && (write[i] || m_pend[i] < MP);
            ev = (i == 0) ? rdv[0] : (!rst && due.size() > 0 && due[0] == cyc);
            chk($sformatf("ready[%0d]", i), ready[i], er);
            chk($sformatf("avm_read[%0d]", i), aread[i], m_busy[i] && !m_wr[i]);
            chk($sformatf("avm_write[%0d]", i), awrite[i], m_busy[i] && m_wr[i]);
            if (m_busy[i] || rst) begin
                chk($sformatf("avm_address[%0d]", i), aaddr[i], m_a[i]);
                chk($sformatf("avm_byteenable[%0d]", i), abe[i], m_be[i]);
                if (m_wr[i] || rst) chk($sformatf("avm_writedata[%0d]", i), awd[i], m_d[i]);
            end
            chk($sformatf("rsp_valid[%0d]", i), rvalid[i], ev);
            if (ev) chk($sformatf("rsp_data[%0d]", i), rsp_d[i], rdata[i]);
            chk($sformatf("pending[%0d]", i), pend[i], m_pend[i]);
            chk($sformatf("protocol_error[%0d]", i), perr[i], m_err[i]);
            if (rst) continue;
            if (i == 1 && ev) void'(due.pop_front());
            if (i == 1 && m_busy[1] && !m_wr[1] && !wreq[1]) due.push_back(cyc + 2);
            hs = valid[i] && er;
            inc = hs && !write[i];
            if (m_busy[i] && !wreq[i]) m_busy[i] = 0;
            if (hs) begin
                m_busy[i] = 1; m_wr[i] = write[i]; m_a[i] = addr[i]; m_be[i] = be[i]; m_d[i] = wdata[i];
            end
            if (ev && m_pend[i] == 0) m_err[i] = 1;
            if (inc && !ev) m_pend[i]++;
            else if (ev && !inc && m_pend[i] > 0) m_pend[i]--;
        end
        cyc++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            valid[i] = 0; write[i] = 0; pause[i] = 0; wreq[i] = 0; rdv[i] = 0;
            addr[i] = '0; be[i] = '0; wdata[i] = '0; rdata[i] = '0;
        end
        repeat (2) tick;
        chk("reset_pending", pend[0], 0);
        chk("reset_error", perr[0], 0);
        chk("reset_read", aread[0], 0);
        rst = 1'b0;
        tick;

        // Single read, response three cycles after acceptance
        valid[0] = 1; write[0] = 0; addr[0] = 14'h10; be[0] = 4'hf;
        settle; chk("s1_ready", ready[0], 1);
        tick; valid[0] = 0;
        chk("s1_read_hi", aread[0], 1); chk("s1_addr", aaddr[0], 14'h10); chk("s1_pend1", pend[0], 1);
        tick; chk("s1_read_lo", aread[0], 0);
        tick; tick;
        rdv[0] = 1; rdata[0] = 32'hDEADBEEF;
        settle; chk("s1_rsp_valid", rvalid[0], 1); chk("s1_rsp_data", rsp_d[0], 32'hDEADBEEF);
        tick; rdv[0] = 0;
        settle; chk("s1_pend0", pend[0], 0); chk("s1_rsp_once", rvalid[0], 0);

        // Four back-to-back reads fill the window
        valid[0] = 1;
        for (int k = 0; k < 4; k++) begin
            addr[0] = AW'(14'h20 + k);
            settle; chk($sformatf("s2_ready%0d", k), ready[0], 1);
            tick;
        end
        addr[0] = 14'h24;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("s2_full%0d", k), ready[0], 0); chk("s2_pend4", pend[0], 4);
            tick;
        end
        rdv[0] = 1; rdata[0] = 32'hA0;
        settle; chk("s2_full_rsp", ready[0], 0);
        tick; rdv[0] = 0;
        settle; chk("s2_reopen", ready[0], 1);
        tick; valid[0] = 0;
        chk("s2_fifth_read", aread[0], 1); chk("s2_fifth_addr", aaddr[0], 14'h24);
        tick;
        for (int k = 0; k < 4; k++) begin
            rdv[0] = 1; rdata[0] = 32'hB0 + k;
            tick;
        end
        rdv[0] = 0;
        settle; chk("s2_drained", pend[0], 0);

        // Write held under waitrequest for five cycles
        valid[0] = 1; write[0] = 1; addr[0] = 14'h33; wdata[0] = 32'h12345678; be[0] = 4'h3; wreq[0] = 1;
        settle; chk("s3_ready", ready[0], 1);
        tick; valid[0] = 0; write[0] = 0;
        for (int k = 0; k < 5; k++) begin
            chk("s3_write", awrite[0], 1); chk("s3_addr", aaddr[0], 14'h33);
            chk("s3_data", awd[0], 32'h12345678); chk("s3_be", abe[0], 4'h3);
            tick;
        end
        wreq[0] = 0;
        settle; chk("s3_write_last", awrite[0], 1); chk("s3_data_last", awd[0], 32'h12345678);
        tick; chk("s3_write_done", awrite[0], 0); chk("s3_pend", pend[0], 0);

        // Pause during a stalled read: it completes, nothing new issues
        valid[0] = 1; addr[0] = 14'h40; wreq[0] = 1;
        tick;
        addr[0] = 14'h41; pause[0] = 1;
        settle; chk("s4_ready_paused", ready[0], 0);
        tick; tick;
        wreq[0] = 0;
        settle; chk("s4_cmd_kept", aread[0], 1); chk("s4_addr_kept", aaddr[0], 14'h40);
        tick; chk("s4_no_new", aread[0], 0);
        tick; chk("s4_no_new2", aread[0], 0);
        valid[0] = 0; pause[0] = 0;
        rdv[0] = 1; rdata[0] = 32'h4040;
        tick; rdv[0] = 0;
        settle; chk("s4_pend", pend[0], 0);

        // Spurious response sets a sticky error
        rdv[0] = 1;
        tick; rdv[0] = 0;
        settle; chk("s6_err_set", perr[0], 1);
        tick; tick; chk("s6_err_held", perr[0], 1); chk("s6_pend_sat", pend[0], 0);

        // Asynchronous reset in the middle of a stalled read
        valid[0] = 1; addr[0] = 14'h50; wreq[0] = 1;
        tick; valid[0] = 0;
        settle; chk("s6_cmd_before_rst", aread[0], 1);
        rst = 1;
        #1;
        chk("s6_rst_read", aread[0], 0); chk("s6_rst_pend", pend[0], 0);
        chk("s6_rst_err", perr[0], 0); chk("s6_rst_addr", aaddr[0], 0);
        rdv[0] = 1;
        tick; tick;
        rdv[0] = 0; rst = 0; wreq[0] = 0;
        tick;
        settle; chk("s6_post_err", perr[0], 0); chk("s6_post_pend", pend[0], 0);
        chk("s6_post_read", aread[0], 0);

        // Fixed latency 2: response in the second cycle after acceptance, readdatavalid ignored
        valid[1] = 1; write[1] = 0; addr[1] = 14'h60; be[1] = 4'hf; rdata[1] = 32'hCAFEF00D;
        settle; chk("s5_ready", ready[1], 1);
        tick; valid[1] = 0; rdv[1] = ~rdv[1];
        chk("s5_read", aread[1], 1); chk("s5_rsp_c0", rvalid[1], 0); chk("s5_pend1", pend[1], 1);
        tick; rdv[1] = ~rdv[1];
        settle; chk("s5_rsp_c1", rvalid[1], 0);
        tick; rdv[1] = ~rdv[1];
        settle; chk("s5_rsp_c2", rvalid[1], 1); chk("s5_rsp_data", rsp_d[1], 32'hCAFEF00D);
        tick; rdv[1] = ~rdv[1];
        settle; chk("s5_rsp_c3", rvalid[1], 0); chk("s5_pend0", pend[1], 0); chk("s5_err", perr[1], 0);
        tick; rdv[1] = 0;
        repeat (3) tick;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/clarvi_avalon_pipe.md
CLARVI_AVALON_PIPE -- requirements
Module: clarvi_avalon_pipe

Interface
Parameters:
REQ-001 SHALL have parameter ADDR_WIDTH, default 14: Avalon word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width, legal 32 or 64.
REQ-003 SHALL have parameter MAX_PENDING, default 4: maximum outstanding reads, power of 2 in 1..16.
REQ-004 SHALL have parameter USE_READDATAVALID, default 1: 1 = variable-latency slave; 0 = fixed-latency slave.
REQ-005 SHALL have parameter FIXED_LATENCY, default 1: read latency in cycles when USE_READDATAVALID=0, legal 1..8.

Ports (name  direction  width  meaning):
REQ-006 SHALL have these ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- core_req_valid  in  1  core request present.
- core_req_ready  out  1  request accepted this cycle.
- core_req_write  in  1  1 = write, 0 = read.
- core_req_address  in  ADDR_WIDTH  word address.
- core_req_byteenable  in  DATA_WIDTH/8  lane enables.
- core_req_writedata  in  DATA_WIDTH  write data.
- core_rsp_valid  out  1  read data valid, one cycle.
- core_rsp_data  out  DATA_WIDTH  read data.
- cpu_mem_pause  in  1  inhibit new Avalon commands.
- avm_address  out  ADDR_WIDTH  Avalon address.
- avm_byteenable  out  DATA_WIDTH/8  Avalon byteenable.
- avm_read  out  1  Avalon read.
- avm_write  out  1  Avalon write.
- avm_writedata  out  DATA_WIDTH  Avalon writedata.
- avm_waitrequest  in  1  Avalon waitrequest.
- avm_readdata  in  DATA_WIDTH  Avalon readdata.
- avm_readdatavalid  in  1  Avalon readdatavalid; ignored when USE_READDATAVALID=0.
- pending_count  out  $clog2(MAX_PENDING+1)  outstanding reads.
- protocol_error  out  1  sticky error flag.

Function
REQ-007 SHALL implement a two-state command FSM, IDLE and CMD; in IDLE, avm_read and avm_write SHALL be 0.
REQ-008 A handshake SHALL occur when core_req_valid && core_req_ready; it registers address, byteenable, writedata and direction into the command register and enters CMD the next cycle.
REQ-009 In CMD, avm_read or avm_write SHALL be driven from the command register, held stable with all command fields while avm_waitrequest=1.
REQ-010 When avm_waitrequest=0 in CMD, the command SHALL be accepted, and the FSM SHALL go to IDLE unless a new handshake occurs in the same cycle, in which case it SHALL stay in CMD with the new command (back-to-back, 1 command/cycle).
REQ-011 core_req_ready SHALL = !cpu_mem_pause && (state==IDLE || !avm_waitrequest) && (core_req_write || pending_count < MAX_PENDING).
REQ-012 cpu_mem_pause SHALL NOT abort a command already in CMD; the command SHALL complete normally.
REQ-013 pending_count SHALL increment on each read handshake and decrement on each read response; with both in the same cycle it SHALL be unchanged.
REQ-014 Writes SHALL NOT change pending_count and SHALL produce no response.
REQ-015 With USE_READDATAVALID=1, core_rsp_valid SHALL equal avm_readdatavalid and core_rsp_data SHALL equal avm_readdata, combinationally (0 added latency).
REQ-016 With USE_READDATAVALID=0, a FIXED_LATENCY-deep valid shift register SHALL be loaded with 1 on each accepted read; its output SHALL act as readdatavalid.
REQ-017 Responses SHALL be returned in issue order, unmodified (no lane shifting).
REQ-018 protocol_error SHALL set when a response arrives with pending_count==0; it SHALL remain set until reset, and pending_count SHALL saturate at 0 in that case.
REQ-019 pending_count SHALL never exceed MAX_PENDING.

Reset
REQ-020 When reset is asserted, the block SHALL asynchronously force: FSM=IDLE; avm_read=0, avm_write=0; avm_address, avm_byteenable and avm_writedata = 0; pending_count=0; protocol_error=0; valid shift register cleared.
REQ-021 Reset asserted mid-transaction SHALL drop the in-flight command and discard any later responses without setting protocol_error until the first clock edge after reset deasserts.

Structure
REQ-022 Package clarvi_pkg SHALL hold the FSM state enum (IDLE, CMD) and a command struct typedef (write, address, byteenable, writedata).
REQ-023 The fixed-latency valid generator SHALL be sub-module clarvi_latency_pipe (parameter DEPTH), instantiated only when USE_READDATAVALID=0.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Read addr 0x10, waitrequest=0, readdatavalid after 3 cycles with 0xDEADBEEF -> avm_read high exactly 1 cycle; core_rsp_valid 1 cycle with 0xDEADBEEF; pending_count 0->1->0.
- 4 back-to-back reads, MAX_PENDING=4, no responses -> all 4 accepted on consecutive cycles; 5th read sees core_req_ready=0 until first readdatavalid.
- Write 0x12345678 byteenable 0x3, waitrequest high 5 cycles -> address, data and byteenable stable for all 6 command cycles; pending_count stays 0.
- cpu_mem_pause asserted during a CMD stalled by waitrequest -> that command completes; no new command issued while pause=1.
- USE_READDATAVALID=0, FIXED_LATENCY=2, read -> core_rsp_valid exactly 2 cycles after command acceptance; avm_readdatavalid toggling ignored.
- readdatavalid with pending_count=0 -> protocol_error=1 and held; reset asserted mid-CMD -> avm_read=0 immediately (asynchronous), all counters 0.
